// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for the adder family: constant clog2,
//               sum-width derivation and the serial accumulator state type.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Width of a sum of cnt unsigned width-bit operands.
  function automatic int owidth_f(input int width, input int cnt);
    return width + clog2(cnt);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/adder_accum_add.sv
// ============================================================================
// Module      : adder_accum_add
// Description : Plain unsigned adder with carry-in, result truncated to WIDTH.
// Ports       : a_i, b_i   - WIDTH-bit operands
//               cin_i      - carry-in
//               sum_o      - WIDTH-bit sum
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_accum_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i + WIDTH'(cin_i);

endmodule : adder_accum_add

`default_nettype wire

// File: rtl/adder_accum.sv
// ============================================================================
// Module      : adder_accum
// Description : Serial accumulator. Takes CNT unsigned operands one per
//               accepted valid/ready beat (or fewer when a beat carries
//               in_flush) and presents one registered OWIDTH-bit sum on a
//               valid/ready output stream.
// Ports       : clk, rst_n             - clock, async active-low reset
//               in_valid/in_ready      - operand stream handshake
//               in_data, in_cin        - operand, carry-in (first beat only)
//               in_flush               - closes the group with this beat
//               sum_valid/sum_ready    - result stream handshake
//               sum_data, sum_count    - sum and number of operands in it
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_accum
  import adder_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int CNT     = 8,
  parameter  int HAS_CIN = 0,
  localparam int OWIDTH  = owidth_f(WIDTH, CNT),
  localparam int CW      = clog2(CNT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_cin,
  input  logic              in_flush,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [OWIDTH-1:0] sum_data,
  output logic [CW-1:0]     sum_count
);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(CNT);

  acc_state_e        state_q;
  logic [OWIDTH-1:0] acc_q;
  logic [OWIDTH-1:0] acc_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              sum_valid_q;
  logic [OWIDTH-1:0] sum_data_q;
  logic [CW-1:0]     sum_count_q;

  logic              accept;
  logic              first;
  logic              last;
  logic              cin_eff;
  logic [OWIDTH-1:0] add_a;

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == IDLE);

  // The first beat of a group restarts from zero, so a previous sum never
  // leaks into the next group.
  assign add_a   = first ? '0 : acc_q;
  assign cin_eff = (HAS_CIN != 0) && first && in_cin;
  assign cnt_d   = first ? CW'(1) : cnt_q + CW'(1);
  // CNT==1 closes on the first beat through the same compare.
  assign last    = in_flush || (cnt_d == C_CNT_LAST);

  adder_accum_add #(
    .WIDTH (OWIDTH)
  ) u_add (
    .a_i   (add_a),
    .b_i   (OWIDTH'(in_data)),
    .cin_i (cin_eff),
    .sum_o (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (last) begin
              state_q     <= DONE;
              sum_valid_q <= 1'b1;
              sum_data_q  <= acc_d;
              sum_count_q <= cnt_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            state_q     <= IDLE;
            sum_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;
  assign sum_count = sum_count_q;

endmodule : adder_accum

`default_nettype wire
